// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the word-addressed data RAM.
// Queues byte-enabled stores, drains them with read-modify-write merge, and gives loads port priority.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        sb_empty,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic hit, ld_grant, drain, enq;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready = (count_q != FULL_CNT);
  assign sb_empty = (count_q == '0);
  assign enq      = st_valid && st_ready;
  assign ld_data  = dm_rd;
  assign ld_stall = hit;

  // Hit looks only at registered entries; a same-cycle enqueue is not visible.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) hit = 1'b1;
    end
    hit = hit && ld_req;
  end

  always_comb begin
    ld_grant = ld_req && !hit;
    drain    = !ld_grant && (count_q != '0);
    dm_we    = drain;
    dm_addr  = '0;
    dm_pc    = '0;
    if (ld_grant) begin
      dm_addr = {ld_addr[31:2], 2'b00};
    end else if (drain) begin
      dm_addr = {addr_q[head_q], 2'b00};
      dm_pc   = pc_q[head_q];
    end
  end

  // Kept apart from the address mux: dm_rd is a combinational function of dm_addr.
  always_comb begin
    dm_wd = '0;
    if (drain) begin
      for (int unsigned b = 0; b < 4; b++) begin
        dm_wd[8*b +: 8] = be_q[head_q][b] ? data_q[head_q][8*b +: 8] : dm_rd[8*b +: 8];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = st_addr[31:2];
      data_d[tail_q]  = st_data;
      be_d[tail_q]    = st_be;
      pc_d[tail_q]    = st_pc;
      tail_d          = tail_q + 1'b1;
    end
    if (enq && !drain)      count_d = count_q + 1'b1;
    else if (drain && !enq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      be_q    <= '{default: '0};
      pc_q    <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a 1024x32 RAM (combinational read, synchronous write).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid;
  logic [31:0] st_addr, st_data, st_pc;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_req;
  logic [31:0] ld_addr, ld_data;
  logic        ld_stall, sb_empty;
  logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;
  logic        dm_we;

  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .sb_empty(sb_empty),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_pc(dm_pc), .dm_rd(dm_rd)
  );

  assign dm_rd = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (dm_we)  mem[dm_addr[11:2]] <= dm_wd;
    if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    step();
    pre_we  = 1'b0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0; st_pc = '0;
    ld_req   = 1'b0; ld_addr = '0;
    pre_we   = 1'b0; pre_idx = '0; pre_val = '0;
    #1;
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_we",    32'(dm_we),    32'd0);
    check("rst_addr",  dm_addr,       32'h0);
    step(); step();
    reset_n = 1'b1;

    preload(10'd12, 32'h55555555);
    preload(10'd13, 32'h66666666);
    preload(10'd64, 32'hCAFEF00D);
    preload(10'd16, 32'h12345678);
    preload(10'd36, 32'h77777777);

    // Test 1: reset while a drain is on the port
    ld_req = 1'b1; ld_addr = 32'h100;
    set_store(32'h30, 32'hDEADBEEF, 4'hF, 32'h1000); step();
    set_store(32'h34, 32'h0BADF00D, 4'hF, 32'h1004); step();
    st_valid = 1'b0; ld_req = 1'b0; #1;
    check("t1_we_pre",   32'(dm_we), 32'd1);
    check("t1_addr_pre", dm_addr,    32'h30);
    reset_n = 1'b0; #1;
    check("t1_we",    32'(dm_we),    32'd0);
    check("t1_empty", 32'(sb_empty), 32'd1);
    check("t1_ready", 32'(st_ready), 32'd1);
    step();
    reset_n = 1'b1; #1;
    check("t1_mem30", mem[12], 32'h55555555);
    check("t1_mem34", mem[13], 32'h66666666);
    check("t1_idle_addr", dm_addr, 32'h0);

    // Test 2: full-word store drains the next cycle
    set_store(32'h10, 32'hAABBCCDD, 4'hF, 32'h2000); step();
    st_valid = 1'b0; #1;
    check("t2_we",   32'(dm_we),    32'd1);
    check("t2_addr", dm_addr,       32'h10);
    check("t2_wd",   dm_wd,         32'hAABBCCDD);
    check("t2_pc",   dm_pc,         32'h2000);
    check("t2_busy", 32'(sb_empty), 32'd0);
    step();
    check("t2_empty", 32'(sb_empty), 32'd1);
    check("t2_mem",   mem[4],        32'hAABBCCDD);

    // Test 3: partial store merges with RAM contents
    preload(10'd4, 32'h11223344);
    set_store(32'h10, 32'h0000EE00, 4'b0010, 32'h2004); step();
    st_valid = 1'b0; #1;
    check("t3_wd", dm_wd, 32'h1122EE44);
    step();
    check("t3_mem", mem[4], 32'h1122EE44);

    // Test 4: fill behind a held load, reject fifth, drain in order with wrap
    ld_req = 1'b1; ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      set_store(32'h80 + 32'(4 * i), 32'(i + 1), 4'hF, 32'h3000 + 32'(4 * i)); #1;
      check("t4_ld_data", ld_data, 32'hCAFEF00D);
      check("t4_nodrain", 32'(dm_we), 32'd0);
      step();
    end
    check("t4_full", 32'(st_ready), 32'd0);
    set_store(32'h90, 32'h5, 4'hF, 32'h3010); step();
    check("t4_still_full", 32'(st_ready), 32'd0);
    st_valid = 1'b0; ld_req = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_addr", dm_addr, 32'h80 + 32'(4 * i));
      check("t4_drain_wd",   dm_wd,   32'(i + 1));
      check("t4_drain_pc",   dm_pc,   32'h3000 + 32'(4 * i));
      step();
      check("t4_ready", 32'(st_ready), 32'd1);
    end
    check("t4_empty",  32'(sb_empty), 32'd1);
    check("t4_idle",   32'(dm_we),    32'd0);
    check("t4_no5th",  mem[36],       32'h77777777);
    check("t4_mem8c",  mem[35],       32'h4);

    // Test 5: load hits two pending stores to the same word
    ld_req = 1'b1; ld_addr = 32'h100;
    set_store(32'h20, 32'h1, 4'hF, 32'h4000); step();
    set_store(32'h20, 32'h2, 4'hF, 32'h4004); step();
    st_valid = 1'b0; ld_addr = 32'h20; #1;
    check("t5_stall0", 32'(ld_stall), 32'd1);
    check("t5_wd0",    dm_wd,         32'h1);
    step();
    check("t5_stall1", 32'(ld_stall), 32'd1);
    check("t5_wd1",    dm_wd,         32'h2);
    step();
    check("t5_release", 32'(ld_stall), 32'd0);
    check("t5_ld_data", ld_data,       32'h2);

    // Test 6: non-conflicting load with a store pending to the neighbouring word
    ld_addr = 32'h100;
    set_store(32'h44, 32'h99, 4'hF, 32'h5000); step();
    st_valid = 1'b0; ld_addr = 32'h40; #1;
    check("t6_stall", 32'(ld_stall), 32'd0);
    check("t6_data",  ld_data,       32'h12345678);
    check("t6_we",    32'(dm_we),    32'd0);
    check("t6_addr",  dm_addr,       32'h40);
    ld_req = 1'b0; step();
    check("t6_mem44", mem[17], 32'h99);

    // Same-cycle enqueue to empty and load to the same word: load is not stalled
    preload(10'd24, 32'h0000AAAA);
    set_store(32'h60, 32'hABCD0000, 4'b1100, 32'h6000);
    ld_req = 1'b1; ld_addr = 32'h60; #1;
    check("t7_stall", 32'(ld_stall), 32'd0);
    check("t7_old",   ld_data,       32'h0000AAAA);
    step();
    st_valid = 1'b0; ld_req = 1'b0; #1;
    check("t7_wd", dm_wd, 32'hABCDAAAA);
    step();
    check("t7_mem", mem[24], 32'hABCDAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory (1024 x 32 RAM, combinational read, synchronous write on MemWrite, address = byte address [11:2]).
- Queues byte-enabled stores in a DEPTH-entry FIFO and drains one entry per free cycle into the RAM. Partial-word stores are read-modify-write merged.
- Arbitrates the RAM's single address port between loads (priority) and drains. Stalls any load whose word address matches a pending store.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request from MEM stage.
- st_addr  input  32  store byte address; bits [1:0] ignored.
- st_data  input  32  store data, already lane-aligned.
- st_be  input  4  byte enables; bit i covers data[8i+7:8i]; 4'b0000 is a legal no-op store.
- st_pc  input  32  PC of the store instruction, carried for the RAM's write trace.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_req  input  1  MEM stage load request.
- ld_addr  input  32  load byte address.
- ld_data  output  32  load data, = dm_rd.
- ld_stall  output  1  load must be held; pipeline freezes.
- sb_empty  output  1  no pending stores; used as a fence before syscall/halt.
- dm_addr  output  32  address to RAM.
- dm_wd  output  32  write data to RAM.
- dm_we  output  1  MemWrite to RAM.
- dm_pc  output  32  PC to RAM.
- dm_rd  input  32  RAM read data for the current dm_addr.

Behaviour:
- Storage: per entry valid, addr[31:2], data, be, pc. Head/tail pointers PTR_W bits wrap modulo DEPTH. Occupancy count is PTR_W+1 bits.
- Reset (reset_n=0, async): all valid bits, pointers and count cleared. While reset holds and after release:
  - st_ready=1, sb_empty=1, dm_we=0, ld_stall=0.
  - dm_addr/dm_wd/dm_pc=0 when idle.
  - A drain in progress when reset asserts is abandoned; no partial write occurs.
- Enqueue: on a rising edge with st_valid && st_ready, write the entry at tail and advance tail. st_ready = (count != DEPTH). It is combinational from registered count only, so a same-cycle drain never frees a slot for an enqueue (no pass-through when full).
- Hit detect (combinational): hit = ld_req && any valid entry addr == ld_addr[31:2]. ld_stall = hit.
- Port arbitration (combinational):
  - ld_req && !hit: dm_addr = {ld_addr[31:2],2'b00}, dm_we=0, no drain this cycle.
  - Otherwise, if count>0: drain head. dm_addr = {head.addr,2'b00}, dm_pc = head.pc, dm_we=1.
  - Otherwise idle: dm_we=0, dm_addr=0.
- Merge: dm_wd byte i = head.be[i] ? head.data byte i : dm_rd byte i. This is valid because the RAM read is combinational on dm_addr. be=4'b1111 yields head.data unchanged.
- Drain commit: on a rising edge with dm_we=1, clear head valid and advance head.
- count update:
  - +1 on enqueue only.
  - -1 on drain only.
  - Unchanged on both or neither.
- Ordering: strictly FIFO. Two stores to the same word drain in program order, so the later bytes win.
- A stalled load releases the port, so the buffer drains until the hit clears. No deadlock is possible.
- sb_empty = (count==0).
- Latency:
  - A store is visible in RAM no earlier than 1 cycle after enqueue.
  - A non-conflicting load has zero added latency.
  - A conflicting load stalls until every matching entry has drained.
- Boundaries:
  - Wrap-around at DEPTH-1 goes to 0.
  - Full: st_valid is ignored and the MEM stage holds its request.
  - Empty with no load: idle.
  - Simultaneous enqueue to empty and ld_req to the same word in the same cycle: hit is evaluated on registered entries only, so the load is not stalled and reads old data. The MEM stage never issues both in one cycle (single-issue).

Test Plan:
1. Reset with reset_n=0 mid-drain (count=2) -> immediately dm_we=0, sb_empty=1, st_ready=1; the RAM word under drain is unchanged.
2. Store addr 0x10, data 0xAABBCCDD, be=4'b1111, no loads -> next cycle dm_we=1, dm_addr=0x10, dm_wd=0xAABBCCDD, dm_pc=st_pc; then sb_empty=1.
3. RAM[0x10]=0x11223344, store be=4'b0010, data=0x0000EE00 -> drain writes 0x1122EE44.
4. Enqueue 4 stores with ld_req held on a non-matching address -> after the 4th, st_ready=0 and a 5th st_valid is not accepted. Drop ld_req -> 4 drains in order, pointers wrap, st_ready=1 after the first drain.
5. Stores to 0x20 (0x1) then 0x20 (0x2); load 0x20 -> ld_stall=1 for 2 drain cycles, then ld_data=0x2.
6. Load 0x40 with a pending store to 0x44 -> ld_stall=0, ld_data=RAM[0x40] same cycle, no drain that cycle.
